// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives instruction memory, and
// loads the F/D pipeline register. Handles hazard stalls and execute-stage
// redirects; a misaligned redirect target halts fetch until reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] f_pc,
  output logic [31:0] f_insn,
  output logic        d_valid,
  output logic [31:0] d_pc,
  output logic [31:0] d_insn,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redirect_aligned;

  assign imem_addr        = pc;
  assign f_pc             = pc;
  assign f_insn           = imem_rdata;
  assign halted           = (state == HALTED);
  assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

  // PC, fetch state and F/D register update; redirect beats stall, reset beats all
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      d_valid     <= 1'b0;
      d_pc        <= '0;
      d_insn      <= NOP_INSN;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (redirect_valid && redirect_aligned) begin
            pc      <= redirect_pc;
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_insn  <= NOP_INSN;
          end else if (redirect_valid) begin
            state   <= HALTED;
            d_valid <= 1'b0;
            d_pc    <= '0;
            d_insn  <= NOP_INSN;
          end else if (!stall) begin
            pc      <= pc + 32'd4;
            d_valid <= 1'b1;
            d_pc    <= pc;
            d_insn  <= imem_rdata;
            if (fetch_count != '1) begin
              fetch_count <= fetch_count + 32'd1;
            end
          end
        end
        HALTED: begin
          d_valid <= 1'b0;
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage. A stimulus process drives one
// vector per cycle and queues the state expected after that edge; a monitor
// pops and compares shortly after each rising edge.
module tb_fetch_stage;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] f_pc;
  logic [31:0] f_insn;
  logic        d_valid;
  logic [31:0] d_pc;
  logic [31:0] d_insn;
  logic        halted;
  logic [31:0] fetch_count;

  typedef struct {
    logic [31:0] pc;
    logic        dv;
    logic [31:0] dpc;
    logic [31:0] dinsn;
    logic        halt;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  fetch_stage #(
    .RESET_PC(32'h0100_0000),
    .NOP_INSN(32'h0000_0013)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .f_pc          (f_pc),
    .f_insn        (f_insn),
    .d_valid       (d_valid),
    .d_pc          (d_pc),
    .d_insn        (d_insn),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  // instruction memory: word tagged with the low address byte
  assign imem_rdata = 32'hAAAA_0000 + {24'h0, imem_addr[7:0]};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // drive one vector on the falling edge and queue the post-edge expectation
  task automatic vec(input logic rst, input logic stl, input logic rv, input logic [31:0] rpc,
                     input logic [31:0] pc, input logic dv, input logic [31:0] dpc,
                     input logic [31:0] dinsn, input logic halt, input logic [31:0] cnt);
    exp_t e;
    @(negedge clock);
    reset          = rst;
    stall          = stl;
    redirect_valid = rv;
    redirect_pc    = rpc;
    e.pc = pc; e.dv = dv; e.dpc = dpc; e.dinsn = dinsn; e.halt = halt; e.cnt = cnt;
    q.push_back(e);
  endtask

  // monitor: compare the DUT against the queued expectation after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("f_pc",        f_pc,                 e.pc);
        chk("imem_addr",   imem_addr,            e.pc);
        chk("f_insn",      f_insn,               32'hAAAA_0000 + {24'h0, e.pc[7:0]});
        chk("d_valid",     {31'h0, d_valid},     {31'h0, e.dv});
        chk("d_pc",        d_pc,                 e.dpc);
        chk("d_insn",      d_insn,               e.dinsn);
        chk("halted",      {31'h0, halted},      {31'h0, e.halt});
        chk("fetch_count", fetch_count,          e.cnt);
      end
    end
  end

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    //   rst  stl  rv   rpc            pc             dv   dpc            dinsn          h    cnt
    // reset and free run
    vec(1'b1,1'b0,1'b0,32'h0,         32'h0100_0000,1'b0,32'h0,        NOP,           1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0004,1'b1,32'h0100_0000,32'hAAAA_0000,1'b0,32'd1);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0008,1'b1,32'h0100_0004,32'hAAAA_0004,1'b0,32'd2);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_000C,1'b1,32'h0100_0008,32'hAAAA_0008,1'b0,32'd3);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0010,1'b1,32'h0100_000C,32'hAAAA_000C,1'b0,32'd4);
    // stall at f_pc=0x01000008
    vec(1'b1,1'b0,1'b0,32'h0,         32'h0100_0000,1'b0,32'h0,        NOP,           1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0004,1'b1,32'h0100_0000,32'hAAAA_0000,1'b0,32'd1);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0008,1'b1,32'h0100_0004,32'hAAAA_0004,1'b0,32'd2);
    vec(1'b0,1'b1,1'b0,32'h0,         32'h0100_0008,1'b1,32'h0100_0004,32'hAAAA_0004,1'b0,32'd2);
    vec(1'b0,1'b1,1'b0,32'h0,         32'h0100_0008,1'b1,32'h0100_0004,32'hAAAA_0004,1'b0,32'd2);
    vec(1'b0,1'b1,1'b0,32'h0,         32'h0100_0008,1'b1,32'h0100_0004,32'hAAAA_0004,1'b0,32'd2);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_000C,1'b1,32'h0100_0008,32'hAAAA_0008,1'b0,32'd3);
    // redirect with simultaneous stall
    vec(1'b0,1'b1,1'b1,32'h0100_0100,32'h0100_0100,1'b0,32'h0,        NOP,           1'b0,32'd3);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0104,1'b1,32'h0100_0100,32'hAAAA_0000,1'b0,32'd4);
    // misaligned redirect halts; everything but reset ignored
    vec(1'b0,1'b0,1'b1,32'h0100_0102,32'h0100_0104,1'b0,32'h0,        NOP,           1'b1,32'd4);
    vec(1'b0,1'b0,1'b1,32'h0100_0200,32'h0100_0104,1'b0,32'h0,        NOP,           1'b1,32'd4);
    vec(1'b0,1'b1,1'b0,32'h0,         32'h0100_0104,1'b0,32'h0,        NOP,           1'b1,32'd4);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0104,1'b0,32'h0,        NOP,           1'b1,32'd4);
    vec(1'b1,1'b0,1'b0,32'h0,         32'h0100_0000,1'b0,32'h0,        NOP,           1'b0,32'd0);
    // PC wrap-around
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0004,1'b1,32'h0100_0000,32'hAAAA_0000,1'b0,32'd1);
    vec(1'b0,1'b0,1'b1,32'hFFFF_FFFC,32'hFFFF_FFFC,1'b0,32'h0,        NOP,           1'b0,32'd1);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0000_0000,1'b1,32'hFFFF_FFFC,32'hAAAA_00FC,1'b0,32'd2);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0000_0004,1'b1,32'h0000_0000,32'hAAAA_0000,1'b0,32'd3);
    // reset beats a same-edge redirect and stall
    vec(1'b1,1'b1,1'b1,32'h0100_0300,32'h0100_0000,1'b0,32'h0,        NOP,           1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0004,1'b1,32'h0100_0000,32'hAAAA_0000,1'b0,32'd1);
    // bit-0 misalignment with stall also halts, pc held
    vec(1'b0,1'b1,1'b1,32'h0100_0001,32'h0100_0004,1'b0,32'h0,        NOP,           1'b1,32'd1);
    vec(1'b1,1'b0,1'b0,32'h0,         32'h0100_0000,1'b0,32'h0,        NOP,           1'b0,32'd0);
    vec(1'b0,1'b0,1'b0,32'h0,         32'h0100_0004,1'b1,32'h0100_0000,32'hAAAA_0000,1'b0,32'd1);
    // let the monitor drain, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    @(negedge clock);
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage RISC-V core; directly upstream of decode.
- Holds the PC and drives the instruction-memory address. Exposes the fetch-side PC and instruction that the top-level trace taps as F_PC and F_INSN.
- Registers the fetched PC and instruction into the F/D pipeline register.
- Handles stalls from the hazard unit and redirects from execute, including taken branches and jumps.

Parameters:
- RESET_PC, 32'h0100_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, encoding injected into decode on bubbles (addi x0,x0,0).

Ports:
- clock  in  1  single clock for the core; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  32  instruction memory address; equals current PC
- imem_rdata  in  32  instruction word; combinational read of imem_addr in the same cycle
- stall  in  1  hazard unit request to hold fetch and the F/D register
- redirect_valid  in  1  execute resolved a taken branch or jump this cycle
- redirect_pc  in  32  redirect target, valid when redirect_valid=1
- f_pc  out  32  current fetch PC (trace signal F_PC)
- f_insn  out  32  current fetched word, equal to imem_rdata (trace signal F_INSN)
- d_valid  out  1  F/D register holds a real instruction
- d_pc  out  32  F/D register PC
- d_insn  out  32  F/D register instruction; NOP_INSN when d_valid=0
- halted  out  1  fetch is stopped because of a misaligned redirect target
- fetch_count  out  32  number of instructions accepted into F/D

Behaviour:
Combinational outputs:
- imem_addr = f_pc = pc.
- f_insn = imem_rdata.
- halted = (state == HALTED).

Reset (reset=1 at a rising edge, from either state, overrides all other inputs):
- pc = RESET_PC, state = RUN.
- d_valid = 0, d_pc = 0, d_insn = NOP_INSN.
- fetch_count = 0.

States:
- RUN: normal fetch.
- HALTED: absorbing state; the only exit is reset.

RUN, evaluated each rising edge in this priority order:
1. Aligned redirect: redirect_valid=1 and redirect_pc[1:0]==0.
   - pc <= redirect_pc.
   - d_valid <= 0, d_pc <= 0, d_insn <= NOP_INSN.
   - fetch_count unchanged.
   - Applies even when stall=1 (redirect beats stall).
2. Misaligned redirect: redirect_valid=1 and redirect_pc[1:0]!=0.
   - state <= HALTED.
   - pc unchanged.
   - d_valid <= 0, d_insn <= NOP_INSN, d_pc <= 0.
3. Stall: stall=1.
   - pc, d_valid, d_pc, d_insn and fetch_count all held.
4. Advance: all other cases.
   - pc <= pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
   - d_pc <= pc, d_insn <= imem_rdata, d_valid <= 1.
   - fetch_count <= fetch_count + 1, saturating at 0xFFFF_FFFF.

HALTED:
- All state held; stall and redirect are ignored.
- d_valid = 0, halted = 1.

Timing:
- Latency from the fetch cycle to visibility on d_*: 1 cycle.
- A redirect presented at edge N produces f_pc = target after edge N and one bubble on d_* after edge N.
- The first real instruction reaches d_* after edge N+1, provided no stall occurs.

Other rules:
- imem_rdata is sampled only in the advance case; its value during stall or redirect cycles does not matter.
- d_insn must never carry a stale word while d_valid=0.
- No X may propagate from imem_rdata into d_* during bubbles.

Test Plan:
1. Reset then free-run 4 cycles, imem returns 0xAAAA0000+addr[7:0]:
   - f_pc sequence is 0x01000000, 0x01000004, 0x01000008, 0x0100000C.
   - After the 2nd edge: d_pc=0x01000000, d_insn=0xAAAA0000, d_valid=1.
   - fetch_count=4.
2. stall=1 for 3 cycles at f_pc=0x01000008:
   - pc, d_pc (0x01000004) and fetch_count are frozen throughout.
   - Release resumes with d_pc=0x01000008 one edge later.
3. Redirect to 0x01000100 with stall=1 in the same cycle:
   - Next cycle: f_pc=0x01000100, d_valid=0, d_insn=0x00000013.
   - Following edge: d_pc=0x01000100, d_valid=1.
4. Redirect to 0x01000102:
   - halted=1, d_valid=0, pc held.
   - Later redirects to 0x01000200 and stall toggling cause no change.
   - reset=1 restores pc=0x01000000, halted=0.
5. Wrap-around: redirect to 0xFFFFFFFC, then advance:
   - f_pc goes 0xFFFFFFFC then 0x00000000.
   - d_pc=0xFFFFFFFC.
6. Reset asserted mid-run with redirect_valid=1 on the same edge:
   - pc=0x01000000, d_valid=0, fetch_count=0.
   - The redirect is ignored.
